// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for fetch and decode
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch stage bus: imem req/gnt/rvalid, decode handshake, redirect
interface ifetch_if;

  logic                     imem_req;
  logic [cpu_pkg::XLEN-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [cpu_pkg::XLEN-1:0] imem_rdata;
  logic                     inst_valid;
  logic                     inst_ready;
  logic [cpu_pkg::XLEN-1:0] inst;
  logic [cpu_pkg::XLEN-1:0] inst_pc;
  logic                     redirect_valid;
  logic [cpu_pkg::XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC, one-outstanding imem fetch, decode buffer
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      inst_d = NOP_INST;
      // A granted or already outstanding request must still be drained.
      case (state_q)
        FETCH:      state_d = bus.imem_gnt ? DROP : FETCH;
        WAIT, DROP: state_d = DROP;
        default:    state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (bus.imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            pc_d    = pc_q + 32'd4;
            inst_d  = NOP_INST;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= PC_INIT;
      inst_q    <= NOP_INST;
      inst_pc_q <= PC_INIT;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed vector table, reset corners and randomized model check for ifetch
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ifetch_if bus ();

  ifetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: flags for "running", "request outstanding",
  // "outstanding response is stale" and "instruction held".
  bit          m_started, m_out, m_stale, m_have;
  logic [31:0] m_pc, m_inst, m_ipc;

  function automatic vec_t v(input logic g, input logic rv, input logic [31:0] rd,
                             input logic rdy, input logic rdr, input logic [31:0] rpc,
                             input logic er, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.gnt = g; t.rvalid = rv; t.rdata = rd; t.ready = rdy; t.redir = rdr; t.rpc = rpc;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_inst = ei; t.e_ipc = ep;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdr, input logic [31:0] rpc);
    bus.imem_gnt       = g;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rd;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
  endtask

  task automatic check(input string nm, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    checks++;
    if (bus.imem_req !== er || bus.imem_addr !== ea || bus.inst_valid !== ev ||
        bus.inst !== ei || bus.inst_pc !== ep) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b inst=%h pc=%h, want req=%0b addr=%h valid=%0b inst=%h pc=%h",
               nm, bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc,
               er, ea, ev, ei, ep);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_out = 0; m_stale = 0; m_have = 0;
    m_pc = 32'h0; m_inst = NOP; m_ipc = 32'h0;
  endtask

  function automatic bit m_req();
    return m_started && !m_out && !m_have;
  endfunction

  task automatic model_step();
    if (bus.redirect_valid) begin
      if (m_req() && bus.imem_gnt) m_out = 1;
      if (m_out) m_stale = 1;
      m_pc      = {bus.redirect_pc[31:2], 2'b00};
      m_have    = 0;
      m_inst    = NOP;
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_have) begin
      if (bus.inst_ready) begin
        m_have = 0;
        m_pc   = m_pc + 32'd4;
        m_inst = NOP;
      end
    end else if (m_out) begin
      if (bus.imem_rvalid) begin
        if (!m_stale) begin
          m_have = 1;
          m_inst = bus.imem_rdata;
          m_ipc  = m_pc;
        end
        m_out   = 0;
        m_stale = 0;
      end
    end else if (bus.imem_gnt) begin
      m_out   = 1;
      m_stale = 0;
    end
  endtask

  initial begin
    vec_t vt[$];
    bit   pend;
    int   dly;
    bit   granted;

    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 0, 32'h0, 0, NOP, 32'h0);
    rst_n = 1'b1;
    #1;
    check("reset_released", 0, 32'h0, 0, NOP, 32'h0);

    vt.push_back(v(1, 0, 0,            0, 0, 0,            1, 32'h0,        0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'h0,        0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h00500093, 0, 0, 0,            0, 32'h0,        1, 32'h00500093, 32'h0));
    for (int i = 0; i < 5; i++)
      vt.push_back(v(0, 0, 0,          0, 0, 0,            0, 32'h0,        1, 32'h00500093, 32'h0));
    vt.push_back(v(0, 0, 0,            1, 0, 0,            1, 32'h4,        0, NOP,          32'h0));
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0, 0, 0,          0, 0, 0,            1, 32'h4,        0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'h4,        0, NOP,          32'h0));
    vt.push_back(v(0, 0, 0,            0, 1, 32'h103,      0, 32'h100,      0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'hDEADBEEF, 0, 0, 0,            1, 32'h100,      0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'h100,      0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h11111111, 0, 1, 32'h40,       0, 32'h40,       0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h22222222, 0, 0, 0,            1, 32'h40,       0, NOP,          32'h0));
    vt.push_back(v(0, 0, 0,            0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'hFFFFFFFC, 0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h00A00113, 0, 0, 0,            0, 32'hFFFFFFFC, 1, 32'h00A00113, 32'hFFFFFFFC));
    vt.push_back(v(0, 0, 0,            1, 0, 0,            1, 32'h0,        0, NOP,          32'hFFFFFFFC));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'h0,        0, NOP,          32'hFFFFFFFC));
    vt.push_back(v(0, 1, 32'h33,       0, 0, 0,            0, 32'h0,        1, 32'h33,       32'h0));
    vt.push_back(v(0, 0, 0,            1, 1, 32'h200,      1, 32'h200,      0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 1, 32'h300,      0, 32'h300,      0, NOP,          32'h0));
    vt.push_back(v(0, 0, 0,            0, 1, 32'h404,      0, 32'h404,      0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h55,       0, 0, 0,            1, 32'h404,      0, NOP,          32'h0));
    vt.push_back(v(1, 0, 0,            0, 0, 0,            0, 32'h404,      0, NOP,          32'h0));
    vt.push_back(v(0, 1, 32'h44,       0, 0, 0,            0, 32'h404,      1, 32'h44,       32'h404));

    foreach (vt[i]) begin
      set_in(vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].redir, vt[i].rpc);
      tick();
      check($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid, vt[i].e_inst, vt[i].e_ipc);
    end

    // Asynchronous reset while holding an instruction, checked between edges.
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_in_hold", 0, 32'h0, 0, NOP, 32'h0);
    tick();
    check("reset_hold_edge", 0, 32'h0, 0, NOP, 32'h0);
    rst_n = 1'b1;
    set_in(0, 1, 32'hBAD0BAD0, 0, 0, 0);
    tick();
    check("late_rvalid_after_reset", 1, 32'h0, 0, NOP, 32'h0);

    // Randomized traffic against the transaction-level model.
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    pend = 0;
    dly  = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.imem_gnt       = ($urandom_range(0, 3) != 0);
      bus.imem_rvalid    = 1'b0;
      if (pend) begin
        if (dly == 0) bus.imem_rvalid = 1'b1;
        else dly--;
      end
      bus.imem_rdata     = $urandom;
      bus.inst_ready     = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc    = $urandom;
      granted = m_req() && bus.imem_gnt;
      model_step();
      tick();
      check($sformatf("rand%0d", c), m_req(), m_pc, m_have, m_inst, m_ipc);
      if (bus.imem_rvalid) pend = 0;
      if (granted) begin
        pend = 1;
        dly  = $urandom_range(0, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
